comp_flag_bank: RTL and testbench

- Parametrised successor to the single compare-flag register. Holds NUM_BANKS independent 12-bit condition vectors, one per thread/channel.
- Each bank tracks outstanding compares with a scoreboard counter, so branch/select logic only reads settled flags.
- A query port evaluates one condition from a chosen bank and returns the result one cycle later.
- Sits between the ALU writeback stage and branch/predicate logic.

---
 rtl/comp_flag_bank.sv | 87 ++++++++
 tb/tb_comp_flag_bank.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/comp_flag_bank.sv
// comp_flag_bank: per-bank 12-bit condition vectors with outstanding-compare scoreboards and a 1-cycle query port; macro COMP_FLAG_BYPASS_EN forwards writeback flags to a waiting query
`ifndef CMP
`define CMP 4'b1000
`endif
module comp_flag_bank #(
  parameter int NUM_BANKS = 4,
  parameter int FLAG_W = 10,
  parameter int MAX_OUT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmp_issue_vld,
  input  logic [$clog2(NUM_BANKS)-1:0] cmp_issue_bank,
  output logic                         cmp_issue_rdy,
  input  logic                         cmp_wb_vld,
  input  logic [3:0]                   ALU_op,
  input  logic [$clog2(NUM_BANKS)-1:0] cmp_wb_bank,
  input  logic [FLAG_W-1:0]            i_comp_flag,
  input  logic                         rd_vld,
  input  logic [$clog2(NUM_BANKS)-1:0] rd_bank,
  input  logic [3:0]                   rd_cond,
  output logic                         rd_rdy,
  output logic                         rd_resp_vld,
  output logic                         rd_true,
  output logic [FLAG_W+1:0]            o_comp_reg,
  output logic                         o_cond_err
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int VW = FLAG_W + 2;
  localparam logic [2:0] MAX_C = 3'(MAX_OUT);
  localparam logic [3:0] CMP_OP = `CMP;
  logic [FLAG_W-1:0] flags [NUM_BANKS];
  logic [2:0] cnt [NUM_BANKS];
  logic [NUM_BANKS-1:0] inc, dec;
  logic issue_fire, wb_fire, byp, cond_bad, wb_err;
  logic [VW-1:0] rd_vec;
  // handshakes, per-bank scoreboard strobes and the vector a query would capture
  always_comb begin
    cmp_issue_rdy = cnt[cmp_issue_bank] < MAX_C;
    issue_fire = cmp_issue_vld && cmp_issue_rdy;
    wb_fire = cmp_wb_vld && ALU_op == CMP_OP;
    wb_err = wb_fire && cnt[cmp_wb_bank] == 3'd0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      inc[i] = issue_fire && cmp_issue_bank == BW'(i);
      dec[i] = wb_fire && cmp_wb_bank == BW'(i);
    end
`ifdef COMP_FLAG_BYPASS_EN
    byp = cnt[rd_bank] == 3'd1 && dec[rd_bank] && !inc[rd_bank];
`else
    byp = 1'b0;
`endif
    rd_rdy = rd_vld && (cnt[rd_bank] == 3'd0 || byp);
    rd_vec = {1'b1, 1'b0, byp ? i_comp_flag : flags[rd_bank]};
    cond_bad = {28'd0, rd_cond} >= VW;
  end
  // flag storage and outstanding counters; a same-bank issue and writeback cancel out, and a writeback never underflows
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        flags[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (dec[i]) flags[i] <= i_comp_flag;
        if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + 3'd1;
        else if (dec[i] && !inc[i] && cnt[i] != 3'd0) cnt[i] <= cnt[i] - 3'd1;
      end
    end
  end
  // registered query response and sticky error for bad conditions or unexpected writebacks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_resp_vld <= 1'b0;
      rd_true <= 1'b0;
      o_comp_reg <= '0;
      o_cond_err <= 1'b0;
    end else begin
      rd_resp_vld <= rd_rdy;
      if (rd_rdy) begin
        o_comp_reg <= rd_vec;
        rd_true <= cond_bad ? 1'b0 : rd_vec[rd_cond];
      end
      if ((rd_rdy && cond_bad) || wb_err) o_cond_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_comp_flag_bank.sv
// tb_comp_flag_bank: directed plus randomized checks of comp_flag_bank against a count/array reference model
`ifndef CMP
`define CMP 4'b1000
`endif
module tb_comp_flag_bank;
  logic clk = 0, reset = 0;
  logic cmp_issue_vld = 0, cmp_wb_vld = 0, rd_vld = 0;
  logic [1:0] cmp_issue_bank = 0, cmp_wb_bank = 0, rd_bank = 0;
  logic [3:0] ALU_op = 0, rd_cond = 0;
  logic [9:0] i_comp_flag = 0;
  logic cmp_issue_rdy, rd_rdy, rd_resp_vld, rd_true, o_cond_err;
  logic [11:0] o_comp_reg;
  int n_cmp = 0, n_bad = 0;
  int mcnt [4];
  logic [9:0] mflg [4];
  bit merr, e_vld, e_true;
  logic [11:0] e_reg;

  comp_flag_bank dut (
    .clk(clk), .reset(reset),
    .cmp_issue_vld(cmp_issue_vld), .cmp_issue_bank(cmp_issue_bank), .cmp_issue_rdy(cmp_issue_rdy),
    .cmp_wb_vld(cmp_wb_vld), .ALU_op(ALU_op), .cmp_wb_bank(cmp_wb_bank), .i_comp_flag(i_comp_flag),
    .rd_vld(rd_vld), .rd_bank(rd_bank), .rd_cond(rd_cond), .rd_rdy(rd_rdy),
    .rd_resp_vld(rd_resp_vld), .rd_true(rd_true), .o_comp_reg(o_comp_reg), .o_cond_err(o_cond_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 0;
      mflg[i] = '0;
    end
    merr = 0;
    e_vld = 0;
    e_true = 0;
    e_reg = '0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".resp_vld"}, rd_resp_vld, e_vld);
    check({tag, ".rd_true"}, rd_true, e_true);
    check({tag, ".comp_reg"}, o_comp_reg, e_reg);
    check({tag, ".cond_err"}, o_cond_err, merr);
  endtask

  task automatic step(input bit iv, input int ib, input bit wv, input logic [3:0] op, input int wb,
                      input logic [9:0] fl, input bit rv, input int rb, input int rc);
    bit irdy, wf, ifire, byp, rrdy;
    logic [11:0] vec;
    @(negedge clk);
    cmp_issue_vld = iv; cmp_issue_bank = 2'(ib);
    cmp_wb_vld = wv; ALU_op = op; cmp_wb_bank = 2'(wb); i_comp_flag = fl;
    rd_vld = rv; rd_bank = 2'(rb); rd_cond = 4'(rc);
    #1;
    irdy = mcnt[ib] < 3;
    wf = wv && op == `CMP;
    ifire = iv && irdy;
    byp = 0;
`ifdef COMP_FLAG_BYPASS_EN
    byp = mcnt[rb] == 1 && wf && wb == rb && !(ifire && ib == rb);
`endif
    rrdy = rv && (mcnt[rb] == 0 || byp);
    check("issue_rdy", cmp_issue_rdy, irdy);
    check("rd_rdy", rd_rdy, rrdy);
    e_vld = rrdy;
    if (rrdy) begin
      vec = {2'b10, byp ? fl : mflg[rb]};
      e_reg = vec;
      e_true = rc < 12 ? vec[rc] : 1'b0;
      if (rc >= 12) merr = 1;
    end
    if (wf && mcnt[wb] == 0) merr = 1;
    if (wf) mflg[wb] = fl;
    if (ifire && !(wf && wb == ib)) mcnt[ib]++;
    if (wf && !(ifire && ib == wb) && mcnt[wb] > 0) mcnt[wb]--;
    @(posedge clk);
    #1;
    check_regs("step");
  endtask

  task automatic idle();
    step(0, 0, 0, 4'd0, 0, 10'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset = 0;
    model_clear();
    #1 check_regs("reset");
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    model_clear();
    #12 check_regs("por");
    @(negedge clk);
    reset = 1;
    step(0, 0, 0, 4'd0, 0, 10'd0, 1, 0, 11);
    check("tp_always", rd_true, 1'b1);
    step(0, 0, 0, 4'd0, 0, 10'd0, 1, 0, 10);
    check("tp_never", rd_true, 1'b0);
    step(1, 1, 0, 4'd0, 0, 10'd0, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0, 10'd0, 1, 1, 9);
    check("tp_pending_vld", rd_resp_vld, 1'b0);
    step(0, 0, 1, `CMP, 1, 10'h200, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0, 10'd0, 1, 1, 9);
    check("tp_eq", rd_true, 1'b1);
    check("tp_vec", o_comp_reg, 12'hA00);
    step(0, 0, 0, 4'd0, 0, 10'd0, 1, 1, 8);
    check("tp_gt", rd_true, 1'b0);
    repeat (3) step(1, 2, 0, 4'd0, 0, 10'd0, 0, 0, 0);
    step(1, 2, 0, 4'd0, 0, 10'd0, 0, 0, 0);
    check("tp_full", cmp_issue_rdy, 1'b0);
    step(0, 0, 1, `CMP, 2, 10'h0f0, 0, 0, 0);
    step(1, 2, 1, `CMP, 2, 10'h0f1, 0, 0, 0);
    step(1, 2, 0, 4'd0, 0, 10'd0, 0, 0, 0);
    step(1, 2, 0, 4'd0, 0, 10'd0, 0, 0, 0);
    check("tp_refull", cmp_issue_rdy, 1'b0);
    check("tp_err_clean", o_cond_err, 1'b0);
    step(0, 0, 1, `CMP, 3, 10'h155, 0, 0, 0);
    check("tp_err_wb", o_cond_err, 1'b1);
    step(0, 0, 0, 4'd0, 0, 10'd0, 1, 3, 13);
    check("tp_bad_cond", rd_true, 1'b0);
    step(0, 0, 1, 4'h3, 3, 10'h2aa, 0, 0, 0);
    step(0, 0, 0, 4'd0, 0, 10'd0, 1, 3, 0);
    check("tp_noncmp", o_comp_reg, 12'h955);
    step(1, 0, 0, 4'd0, 0, 10'd0, 0, 0, 0);
    step(0, 0, 1, `CMP, 0, 10'h3c3, 1, 0, 0);
`ifdef COMP_FLAG_BYPASS_EN
    check("tp_byp_vec", o_comp_reg, 12'hBC3);
`else
    check("tp_nobyp_vld", rd_resp_vld, 1'b0);
`endif
    step(0, 0, 0, 4'd0, 0, 10'd0, 1, 0, 0);
    check("tp_after_vld", rd_resp_vld, 1'b1);
    idle();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      step($urandom_range(0, 1), $urandom_range(0, 3),
           $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0 ? 4'($urandom) : `CMP,
           $urandom_range(0, 3), 10'($urandom), $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 15));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
